// File: rtl/push_debouncer.sv
// push_debouncer: two-channel active-low key synchroniser and debouncer feeding the counter's i_Push.
// Optional auto-repeat while a key is held is compiled in when DEBOUNCE_REPEAT_EN is defined.
module push_debouncer #(
    parameter int DB_CYCLES     = 1_000_000,
    parameter int REPEAT_DELAY  = 25_000_000,
    parameter int REPEAT_PERIOD = 5_000_000
) (
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic [1:0] i_Push,
    output logic [1:0] o_Push,
    output logic [1:0] o_Press
);
    localparam int CW = $clog2(DB_CYCLES);
    localparam logic [CW-1:0] DB_LAST = CW'(DB_CYCLES - 1);

    typedef enum logic [1:0] {RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT} state_t;

    if (DB_CYCLES < 2 || REPEAT_PERIOD < 2 || REPEAT_DELAY <= REPEAT_PERIOD) begin : g_bad_params
        $error("push_debouncer: invalid timing parameters");
    end

    for (genvar g = 0; g < 2; g++) begin : g_ch
        logic          r_S1;
        logic          r_S2;
        state_t        r_State;
        logic [CW-1:0] r_Cnt;
        logic          r_Push;
        logic          r_Press;
`ifdef DEBOUNCE_REPEAT_EN
        localparam int HW = $clog2(REPEAT_DELAY);
        localparam logic [HW-1:0] HOLD_LAST   = HW'(REPEAT_DELAY - 1);
        localparam logic [HW-1:0] HOLD_RELOAD = HW'(REPEAT_DELAY - REPEAT_PERIOD);
        logic [HW-1:0] r_Hold;
`endif

        // two-flop synchroniser, idles at released (1)
        always_ff @(posedge i_Clk or posedge i_Rst) begin
            if (i_Rst) begin
                r_S1 <= 1'b1;
                r_S2 <= 1'b1;
            end else begin
                r_S1 <= i_Push[g];
                r_S2 <= r_S1;
            end
        end

        // debounce FSM: a level is accepted only after DB_CYCLES stable samples; outputs registered
        always_ff @(posedge i_Clk or posedge i_Rst) begin
            if (i_Rst) begin
                r_State <= RELEASED;
                r_Cnt   <= '0;
                r_Push  <= 1'b1;
                r_Press <= 1'b0;
`ifdef DEBOUNCE_REPEAT_EN
                r_Hold  <= '0;
`endif
            end else begin
                r_Press <= 1'b0;
                case (r_State)
                    RELEASED: begin
                        if (!r_S2) begin
                            r_State <= PRESS_WAIT;
                            r_Cnt   <= '0;
                        end
                    end
                    PRESS_WAIT: begin
                        if (r_S2) begin
                            r_State <= RELEASED;
                            r_Cnt   <= '0;
                        end else if (r_Cnt == DB_LAST) begin
                            r_State <= PRESSED;
                            r_Cnt   <= '0;
                            r_Push  <= 1'b0;
                            r_Press <= 1'b1;
`ifdef DEBOUNCE_REPEAT_EN
                            r_Hold  <= '0;
`endif
                        end else begin
                            r_Cnt <= r_Cnt + 1'b1;
                        end
                    end
                    PRESSED: begin
                        r_Push <= 1'b0;
                        if (r_S2) begin
                            r_State <= RELEASE_WAIT;
                            r_Cnt   <= '0;
                        end
`ifdef DEBOUNCE_REPEAT_EN
                        else if (r_Hold == HOLD_LAST) begin
                            r_Push  <= 1'b1;
                            r_Press <= 1'b1;
                            r_Hold  <= HOLD_RELOAD;
                        end else begin
                            r_Hold <= r_Hold + 1'b1;
                        end
`endif
                    end
                    RELEASE_WAIT: begin
                        if (!r_S2) begin
                            r_State <= PRESSED;
                            r_Cnt   <= '0;
                        end else if (r_Cnt == DB_LAST) begin
                            r_State <= RELEASED;
                            r_Cnt   <= '0;
                            r_Push  <= 1'b1;
                        end else begin
                            r_Cnt <= r_Cnt + 1'b1;
                        end
                    end
                endcase
            end
        end

        assign o_Push[g]  = r_Push;
        assign o_Press[g] = r_Press;
    end
endmodule

// File: tb/tb_push_debouncer.sv
// tb_push_debouncer: directed and random key stimulus against a stable-time reference model.
module tb_push_debouncer;
    localparam int DB = 4;
    localparam int RD = 20;
    localparam int RP = 8;

    logic       i_Clk = 1'b0;
    logic       i_Rst = 1'b1;
    logic [1:0] i_Push = 2'b00;
    logic [1:0] o_Push;
    logic [1:0] o_Press;

    int n_total = 0;
    int n_bad   = 0;

    logic [1:0] m_s1, m_s2, m_lvl, m_out, m_pr;
    int         m_run [2];
    int         m_tick [2];

    push_debouncer #(
        .DB_CYCLES(DB),
        .REPEAT_DELAY(RD),
        .REPEAT_PERIOD(RP)
    ) dut (
        .i_Clk(i_Clk),
        .i_Rst(i_Rst),
        .i_Push(i_Push),
        .o_Push(o_Push),
        .o_Press(o_Press)
    );

    always #5 i_Clk = ~i_Clk;

    task automatic chk(input string tag, input logic [1:0] got, input logic [1:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%b exp=%b at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_s1  = 2'b11;
        m_s2  = 2'b11;
        m_lvl = 2'b11;
        m_out = 2'b11;
        m_pr  = 2'b00;
        for (int c = 0; c < 2; c++) begin
            m_run[c]  = 0;
            m_tick[c] = 0;
        end
    endtask

    // A level flips once the doubly-delayed raw key has disagreed with it for DB+1 consecutive edges.
    // Auto-repeat fires when time spent settled-pressed reaches RD, then every RP after that.
    task automatic model_edge();
        for (int c = 0; c < 2; c++) begin
            logic x;
            logic rep;
            x = m_s2[c];
            rep = 1'b0;
            m_pr[c] = 1'b0;
            m_s2[c] = m_s1[c];
            m_s1[c] = i_Push[c];
            if (x != m_lvl[c]) begin
                m_run[c]++;
                if (m_run[c] == DB + 1) begin
                    m_lvl[c] = x;
                    m_run[c] = 0;
                    if (!x) begin
                        m_pr[c]   = 1'b1;
                        m_tick[c] = 0;
                    end
                end
            end else begin
`ifdef DEBOUNCE_REPEAT_EN
                if (!m_lvl[c] && m_run[c] == 0) begin
                    m_tick[c]++;
                    rep = (m_tick[c] >= RD) && ((m_tick[c] - RD) % RP == 0);
                end
`endif
                m_run[c] = 0;
            end
            m_out[c] = m_lvl[c] | rep;
            m_pr[c]  = m_pr[c] | rep;
        end
    endtask

    task automatic cyc(input logic [1:0] p);
        i_Push = p;
        @(posedge i_Clk);
        if (!i_Rst) model_edge();
        @(negedge i_Clk);
        chk("o_Push", o_Push, m_out);
        chk("o_Press", o_Press, m_pr);
    endtask

    task automatic cycn(input logic [1:0] p, input int n);
        for (int i = 0; i < n; i++) cyc(p);
    endtask

    task automatic do_arst();
        #2 i_Rst = 1'b1;
        model_reset();
        #1;
        chk("arst_push", o_Push, 2'b11);
        chk("arst_press", o_Press, 2'b00);
        @(negedge i_Clk);
        chk("arst_hold", o_Push, 2'b11);
        i_Rst = 1'b0;
    endtask

    initial begin
        int len [2];
        logic [1:0] lvl;
        model_reset();
        repeat (3) @(negedge i_Clk);
        chk("rst_push", o_Push, 2'b11);
        chk("rst_press", o_Press, 2'b00);
        i_Rst = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            cyc(2'b00);
            if (i == 6) chk("rst_lat_pre", o_Push, 2'b11);
            if (i == 7) begin
                chk("rst_lat_push", o_Push, 2'b00);
                chk("rst_lat_press", o_Press, 2'b11);
            end
            if (i == 8) chk("rst_one_pulse", o_Press, 2'b00);
        end
        cycn(2'b11, 10);
        cycn(2'b01, 30);
        cycn(2'b11, 10);
        cycn(2'b10, 2); cycn(2'b11, 2); cycn(2'b10, 2); cycn(2'b11, 2);
        cycn(2'b10, 12);
        cycn(2'b11, 3);
        cycn(2'b10, 10);
        cycn(2'b11, 10);
        cycn(2'b01, 75);
        cycn(2'b11, 10);
        cycn(2'b01, 10);
        do_arst();
        cycn(2'b01, 12);
        cycn(2'b11, 10);
        lvl = 2'b11;
        len[0] = 0;
        len[1] = 0;
        for (int n = 0; n < 3000; n++) begin
            for (int c = 0; c < 2; c++) begin
                if (len[c] == 0) begin
                    lvl[c] = ~lvl[c];
                    len[c] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 5) : $urandom_range(5, 60);
                end
                len[c]--;
            end
            cyc(lvl);
            if (n == 1500) do_arst();
        end
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule

// File: doc/push_debouncer.md
# push_debouncer

Two-channel push-button conditioner for the board's active-low keys. It sits directly upstream of the up/down counter's `i_Push` input. Each raw key is synchronised, debounced with a stable-time counter and presented as a clean active-low level, so the counter's own falling-edge detection sees exactly one edge per physical press. An optional auto-repeat mode generates extra press edges while a key is held.

## Interface
- DB_CYCLES, 1_000_000: consecutive stable cycles required to accept a level change (20 ms at 50 MHz); must be ≥ 2.
- REPEAT_DELAY, 25_000_000: cycles from accepted press to the first repeat; must be > REPEAT_PERIOD.
- REPEAT_PERIOD, 5_000_000: cycles between repeats; must be ≥ 2.
- i_Clk  input  1  system clock, 50 MHz, rising edge.
- i_Rst  input  1  reset, asynchronous, active-high.
- i_Push  input  2  raw keys, active-low, asynchronous to i_Clk; bit 1 = up, bit 0 = down.
- o_Push  output  2  debounced keys, active-low level; drives the counter's i_Push.
- o_Press  output  2  one-cycle active-high pulse per accepted press or repeat.

## Operation
- Both channels are identical and fully independent. Every register below is per channel.
- Synchroniser: two flops, s1 then s2, both reset to 1 (released). The FSM uses only s2.
- Stable counter cnt: width $clog2(DB_CYCLES), reset 0, cleared on every FSM state change.
- FSM states: RELEASED (reset), PRESS_WAIT, PRESSED, RELEASE_WAIT.
  - RELEASED: when s2 = 0, go to PRESS_WAIT.
  - PRESS_WAIT: when s2 = 1, go back to RELEASED (bounce rejected). Otherwise increment cnt; when cnt = DB_CYCLES-1, go to PRESSED.
  - PRESSED: when s2 = 1, go to RELEASE_WAIT.
  - RELEASE_WAIT: when s2 = 0, go back to PRESSED; no new press is reported and the hold counter is not cleared. Otherwise increment cnt; when cnt = DB_CYCLES-1, go to RELEASED.
- o_Push output:
  - 0 in PRESSED and RELEASE_WAIT.
  - 1 in RELEASED and PRESS_WAIT.
  - Also 1 during a repeat cycle (see Configuration).
- o_Press pulses for one cycle on the cycle the FSM enters PRESSED from PRESS_WAIT, and on each repeat cycle.
- o_Push and o_Press are registered outputs; there is no combinational path from i_Push.
- Reset values: o_Push = 2'b11, o_Press = 2'b00, state = RELEASED, cnt = 0, s1 = s2 = 1.
- Reset asserted mid-press forces the released state immediately. After reset is released, a key still held down is accepted as a new press after the normal latency.

## Timing
- Let k be the edge at which s1 first captures raw 0.
  - s2 = 0 at k+1.
  - PRESS_WAIT at k+2.
  - PRESSED, with o_Push = 0 and the o_Press pulse, at k+DB_CYCLES+2.
- Release latency is symmetric: o_Push returns to 1 DB_CYCLES+2 edges after the first raw-1 sample.
- A bounce shorter than DB_CYCLES cycles on either level produces no output change.
- Simultaneous presses on both channels are handled independently. Both o_Press bits may pulse in the same cycle.

## Configuration
- Macro: DEBOUNCE_REPEAT_EN.
- Defined (auto-repeat compiled in):
  - A hold counter (width $clog2(REPEAT_DELAY)) clears on the PRESS_WAIT→PRESSED transition and counts only in PRESSED.
  - First repeat occurs REPEAT_DELAY cycles after o_Push fell; later repeats follow every REPEAT_PERIOD cycles.
  - A repeat cycle sets o_Push = 1 and o_Press = 1 for exactly one cycle, then o_Push returns to 0. The state stays PRESSED.
  - Entering RELEASE_WAIT freezes the hold counter. Reaching RELEASED discards it.
- Not defined: no hold counter logic is generated, and REPEAT_DELAY and REPEAT_PERIOD are unused. There is exactly one o_Press pulse and one falling edge of o_Push per accepted press.

## Test plan
Bench parameters: DB_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8.
- Reset: assert i_Rst with i_Push=2'b00 → o_Push=2'b11 and o_Press=2'b00 while reset is held. After release, o_Push=2'b00 at edge k+6 with one o_Press=2'b11 pulse.
- Clean press: i_Push[1] falls, is held 30 cycles, then rises (macro off) → o_Push[1] falls 6 edges after the first low sample, one o_Press[1] pulse, o_Push[1] rises 6 edges after the first high sample. Channel 0 is unchanged throughout.
- Bounce rejection: i_Push[0] toggles 0/1/0/1 with 2-cycle phases, then settles low → no output during the bounce; o_Push[0]=0 exactly DB_CYCLES+2 edges after the last low transition.
- Release glitch: key held, 3-cycle high glitch → o_Push stays 0 and there is no new o_Press.
- Auto-repeat (macro on): hold key 60 cycles after acceptance → o_Press pulses at +0, +20, +28, +36, +44, +52, each with o_Push=1 for exactly one cycle.
- Mid-press reset: assert i_Rst while in PRESSED → o_Push=1 immediately (asynchronously). After release with the key still low, re-acceptance occurs after DB_CYCLES+2 edges.
